// File: rtl/mem_stage.sv
// mem_stage: MIPS memory stage with req/ready data-memory handshake, load alignment/extension and MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses with a mem_err pulse.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] aluResult1_PR,
  input  logic [31:0] readDataB1_PR,
  input  logic [31:0] Instr1_PR,
  input  logic [4:0]  writeRegister1_PR,
  input  logic        MemRead1_PR,
  input  logic        MemWrite1_PR,
  input  logic        MemtoReg1_PR,
  input  logic        do_writeback1_PR,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  output logic        STALL,
  output logic [31:0] Data1_MEM,
  output logic [4:0]  writeRegister1_MEM,
  output logic        do_writeback1_MEM,
  output logic [31:0] Data1_WB,
  output logic [4:0]  writeRegister1_WB,
  output logic        do_writeback1_WB,
  output logic        mem_err
);
  typedef enum logic {IDLE, WAIT} state_t;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] sz, off;
  logic is_byte, is_half, unsgn, mem_op, misalign, timeout;
  logic [31:0] lane, ext;
  assign sz      = Instr1_PR[27:26];
  assign unsgn   = Instr1_PR[28];
  assign is_byte = sz == 2'b00;
  assign is_half = sz == 2'b01;
  always_comb begin
    mem_op = MemRead1_PR | MemWrite1_PR;
    off = is_byte ? aluResult1_PR[1:0] : is_half ? {aluResult1_PR[1], 1'b0} : 2'b00;
`ifdef MEM_ALIGN_CHECK_EN
    misalign = mem_op & (is_half ? aluResult1_PR[0] : (!is_byte && aluResult1_PR[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    // a WAIT cycle that hits the limit without ready abandons the access
    timeout = (TIMEOUT != 0) && state == WAIT && cnt == CW'(TIMEOUT) && !dmem_ready;
    dmem_req = RESET & mem_op & ~misalign & ~timeout;
    dmem_we = MemWrite1_PR & ~MemRead1_PR;
    dmem_addr = {aluResult1_PR[31:2], 2'b00};
    dmem_wdata = is_byte ? {4{readDataB1_PR[7:0]}} : is_half ? {2{readDataB1_PR[15:0]}} : readDataB1_PR;
    dmem_be = is_byte ? 4'b0001 << off : is_half ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    lane = dmem_rdata >> {off, 3'b000};
    ext = is_byte ? {{24{~unsgn & lane[7]}}, lane[7:0]} :
          is_half ? {{16{~unsgn & lane[15]}}, lane[15:0]} : dmem_rdata;
    STALL = dmem_req & ~dmem_ready;
    Data1_MEM = MemtoReg1_PR ? ext : aluResult1_PR;
    writeRegister1_MEM = writeRegister1_PR;
    do_writeback1_MEM = do_writeback1_PR & ~STALL;
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state <= IDLE;
      cnt <= '0;
      Data1_WB <= '0;
      writeRegister1_WB <= '0;
      do_writeback1_WB <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      state <= STALL ? WAIT : IDLE;
      cnt <= STALL ? cnt + 1'b1 : '0;
      mem_err <= timeout | misalign;
      if (STALL | timeout | misalign) do_writeback1_WB <= 1'b0;
      else begin
        Data1_WB <= Data1_MEM;
        writeRegister1_WB <= writeRegister1_PR;
        do_writeback1_WB <= do_writeback1_PR;
      end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed checks of mem_stage against an arithmetic reference model.
module tb_mem_stage;
  localparam int TO = 16;
  logic CLK = 1'b0, RESET = 1'b0;
  logic [31:0] aluResult1_PR = '0, readDataB1_PR = '0, Instr1_PR = '0, dmem_rdata = '0;
  logic [4:0] writeRegister1_PR = '0;
  logic MemRead1_PR = 0, MemWrite1_PR = 0, MemtoReg1_PR = 0, do_writeback1_PR = 0, dmem_ready = 0;
  logic dmem_req, dmem_we, STALL, do_writeback1_MEM, do_writeback1_WB, mem_err;
  logic [31:0] dmem_addr, dmem_wdata, Data1_MEM, Data1_WB;
  logic [3:0] dmem_be;
  logic [4:0] writeRegister1_MEM, writeRegister1_WB;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_data = '0;
  logic [4:0] m_reg = '0;
  logic m_wbv = 0, m_err = 0;

  mem_stage #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .aluResult1_PR(aluResult1_PR), .readDataB1_PR(readDataB1_PR),
    .Instr1_PR(Instr1_PR), .writeRegister1_PR(writeRegister1_PR), .MemRead1_PR(MemRead1_PR),
    .MemWrite1_PR(MemWrite1_PR), .MemtoReg1_PR(MemtoReg1_PR), .do_writeback1_PR(do_writeback1_PR),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .STALL(STALL),
    .Data1_MEM(Data1_MEM), .writeRegister1_MEM(writeRegister1_MEM), .do_writeback1_MEM(do_writeback1_MEM),
    .Data1_WB(Data1_WB), .writeRegister1_WB(writeRegister1_WB), .do_writeback1_WB(do_writeback1_WB),
    .mem_err(mem_err));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [5:0] op);
    return (op % 4 == 0) ? 1 : (op % 4 == 1) ? 2 : 4;
  endfunction

  function automatic int off_of(input logic [5:0] op, input logic [31:0] a);
    int sz = size_of(op);
    return sz == 1 ? int'(a % 4) : sz == 2 ? int'(a % 4) / 2 * 2 : 0;
  endfunction

  function automatic logic [31:0] ext_m(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rdv);
    int sz = size_of(op);
    logic sgn = op < 6'h24;
    logic [31:0] v = rdv >> (8 * off_of(op, a));
    if (sz == 1) begin
      v = v % 256;
      if (sgn && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 2) begin
      v = v % 65536;
      if (sgn && v >= 32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic mis_m(input logic [5:0] op, input logic [31:0] a, input logic mem);
`ifdef MEM_ALIGN_CHECK_EN
    return mem && ((size_of(op) == 2 && a % 2 != 0) || (size_of(op) == 4 && a % 4 != 0));
`else
    return 1'b0 & mem & op[0] & a[0];
`endif
  endfunction

  task automatic check_regs();
    chk("mem_err", mem_err, m_err);
    chk("wb_en", do_writeback1_WB, m_wbv);
    chk("wb_data", Data1_WB, m_data);
    chk("wb_reg", writeRegister1_WB, m_reg);
  endtask

  task automatic run(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt,
                     input logic rd, input logic wr, input logic m2r, input logic dw,
                     input logic [4:0] rg, input logic [31:0] rdv, input int lat, output int nstall);
    logic mem = rd | wr;
    logic mis = mis_m(op, a, mem);
    int sz = size_of(op), off = off_of(op, a), c = 0;
    logic done = 0, rdy, to, req_e, stall_e;
    logic [31:0] be_e, wd_e, d_e;
    nstall = 0;
    be_e = sz == 1 ? 32'd1 << off : sz == 2 ? 32'd3 << off : 32'd15;
    wd_e = sz == 1 ? (rt % 256) * 32'h01010101 : sz == 2 ? (rt % 65536) * 32'h00010001 : rt;
    d_e = m2r ? ext_m(op, a, rdv) : a;
    while (!done) begin
      @(negedge CLK);
      check_regs();
      rdy = mem ? (c == lat) : 1'($urandom % 2);
      aluResult1_PR = a; readDataB1_PR = rt; Instr1_PR = {op, 26'($urandom)};
      writeRegister1_PR = rg; MemRead1_PR = rd; MemWrite1_PR = wr; MemtoReg1_PR = m2r;
      do_writeback1_PR = dw; dmem_rdata = rdv; dmem_ready = rdy;
      #1;
      to = TO != 0 && c == TO && !rdy && mem && !mis;
      req_e = mem && !mis && !to;
      stall_e = req_e && !rdy;
      chk("req", dmem_req, req_e);
      chk("stall", STALL, stall_e);
      chk("we", dmem_we, wr && !rd);
      chk("addr", dmem_addr, a - a % 4);
      chk("data_mem", Data1_MEM, d_e);
      chk("reg_mem", writeRegister1_MEM, rg);
      chk("wb_mem", do_writeback1_MEM, dw && !stall_e);
      if (req_e) begin
        chk("be", dmem_be, be_e);
        chk("wdata", dmem_wdata, wd_e);
      end
      m_err = to || mis;
      if (stall_e || to || mis) m_wbv = 0;
      else begin
        m_data = d_e; m_reg = rg; m_wbv = dw;
      end
      nstall += int'(stall_e);
      c++;
      done = !stall_e;
    end
  endtask

  initial begin
    int ns;
    logic [5:0] lds[5] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    logic [5:0] sts[3] = '{6'h28, 6'h29, 6'h2B};
    #1;
    chk("rst_req", dmem_req, 0);
    check_regs();
    @(negedge CLK); @(negedge CLK);
    RESET = 1;
    run(6'h23, 32'h100, 0, 1, 0, 1, 1, 5'd5, 32'hDEADBEEF, 0, ns);
    chk("t1_stalls", ns, 0);
    @(posedge CLK); #1;
    chk("t1_data", Data1_WB, 32'hDEADBEEF);
    run(6'h20, 32'h103, 0, 1, 0, 1, 1, 5'd6, 32'h80FFFFFF, 0, ns);
    @(posedge CLK); #1;
    chk("t2_lb", Data1_WB, 32'hFFFFFF80);
    run(6'h24, 32'h103, 0, 1, 0, 1, 1, 5'd6, 32'h80FFFFFF, 0, ns);
    @(posedge CLK); #1;
    chk("t2_lbu", Data1_WB, 32'h00000080);
    run(6'h29, 32'h102, 32'h1234, 0, 1, 0, 0, 5'd0, 32'h0, 0, ns);
    chk("t3_be", dmem_be, 4'b1100);
    chk("t3_wdata", dmem_wdata, 32'h12341234);
    run(6'h23, 32'h104, 0, 1, 0, 1, 1, 5'd7, 32'hCAFEF00D, 3, ns);
    chk("t4_stalls", ns, 3);
    run(6'h23, 32'h108, 0, 1, 0, 1, 1, 5'd8, 32'h11111111, 1000, ns);
    chk("t5_stalls", ns, TO);
    @(posedge CLK); #1;
    chk("t5_err", mem_err, 1);
    chk("t5_wb", do_writeback1_WB, 0);
    run(6'h23, 32'h101, 0, 1, 0, 1, 1, 5'd9, 32'h55667788, 0, ns);
    // reset while a load waits for memory
    @(negedge CLK);
    aluResult1_PR = 32'h200; Instr1_PR = {6'h23, 26'd0}; MemRead1_PR = 1; MemWrite1_PR = 0;
    MemtoReg1_PR = 1; do_writeback1_PR = 1; writeRegister1_PR = 5'd3; dmem_ready = 0;
    @(negedge CLK); @(negedge CLK);
    chk("rw_stall", STALL, 1);
    RESET = 0; #1;
    chk("rw_req", dmem_req, 0);
    chk("rw_stall0", STALL, 0);
    chk("rw_wb", do_writeback1_WB, 0);
    chk("rw_data", Data1_WB, 0);
    aluResult1_PR = 0; MemRead1_PR = 0; MemtoReg1_PR = 0; do_writeback1_PR = 0; writeRegister1_PR = 0;
    @(negedge CLK);
    RESET = 1;
    m_data = 0; m_reg = 0; m_wbv = 0; m_err = 0;
    for (int i = 0; i < 300; i++) begin
      int k = int'($urandom % 8), lat = int'($urandom % 6);
      logic [5:0] op;
      logic rd, wr;
      if (lat == 5) lat = ($urandom % 3 == 0) ? 1000 : 0;
      rd = k inside {[1:3], 7};
      wr = k inside {[4:5], 7};
      op = wr && !rd ? sts[$urandom % 3] : rd ? lds[$urandom % 5] : 6'($urandom % 16);
      run(op, $urandom, $urandom, rd, wr, rd, rd ? 1'($urandom % 4 != 0) : 1'($urandom % 2),
          5'($urandom), $urandom, lat, ns);
    end
    @(negedge CLK);
    check_regs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
